// File: rtl/mac_stream_ctrl.sv
// mac_stream_ctrl: issues (activation, weight) pairs to an external MAC,
// chains the MAC result back as the next partial sum, presents the final
// psum after len pairs, and cross-checks every MAC result against its own
// recomputation.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid must hold (with stable data) until ready; ready may
// depend on state but never on the same-side valid.
module mac_stream_ctrl #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int len     = 10,
   parameter int mac_lat = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [bw-1:0]      in_x,
   input  logic [bw-1:0]      in_w,
   output logic [bw-1:0]      mac_a,
   output logic [bw-1:0]      mac_b,
   output logic [psum_bw-1:0] mac_c,
   input  logic [psum_bw-1:0] mac_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [psum_bw-1:0] out_psum,
   output logic [7:0]         err_cnt,
   output logic               err_flag
);

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [psum_bw-1:0] acc;
   logic [psum_bw-1:0] exp_val;
   logic [7:0]         count;
   logic [2:0]         wait_cnt;

   logic [psum_bw-1:0] w_ext;
   logic [psum_bw-1:0] x_ext;
   logic [psum_bw-1:0] prod;
   logic               take_in;
   logic               capture;
   logic               last_pair;
   logic               mismatch;

   // Signed weight times unsigned activation, kept modulo 2^psum_bw.
   assign w_ext     = {{(psum_bw-bw){in_w[bw-1]}}, in_w};
   assign x_ext     = {{(psum_bw-bw){1'b0}}, in_x};
   assign prod      = w_ext * x_ext;

   assign take_in   = (state == ISSUE) && in_valid;
   assign capture   = (state == WAIT) && (wait_cnt == 3'd1);
   assign last_pair = (count == 8'(len - 1));
   assign mismatch  = capture && (mac_out != exp_val);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ISSUE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ISSUE:   if (in_valid)  state_nxt = WAIT;
         WAIT:    if (capture)   state_nxt = last_pair ? DONE : ISSUE;
         DONE:    if (out_ready) state_nxt = ISSUE;
         default:                state_nxt = ISSUE;
      endcase
   end

   // Handshake outputs, forced low while reset is asserted.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      if (!reset) begin
         in_ready  = (state == ISSUE);
         out_valid = (state == DONE);
      end
   end

   // Operand issue, result capture, accumulation and mismatch bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         exp_val  <= '0;
         count    <= '0;
         wait_cnt <= '0;
         mac_a    <= '0;
         mac_b    <= '0;
         mac_c    <= '0;
         out_psum <= '0;
         err_cnt  <= '0;
         err_flag <= 1'b0;
      end else begin
         if (take_in) begin
            mac_a    <= in_x;
            mac_b    <= in_w;
            mac_c    <= acc;
            exp_val  <= acc + prod;
            wait_cnt <= 3'(mac_lat);
         end
         if (state == WAIT) begin
            wait_cnt <= wait_cnt - 3'd1;
         end
         if (capture) begin
            // Accumulate the MAC's own result so one bad result is counted once.
            acc <= mac_out;
            if (last_pair) begin
               count    <= '0;
               out_psum <= mac_out;
            end else begin
               count <= count + 8'd1;
            end
         end
         if (mismatch) begin
            err_flag <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end
         if ((state == DONE) && out_ready) begin
            acc <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Bench for mac_stream_ctrl: three instances (len=4/lat=1, len=4/lat=3,
// len=255/lat=1), each fed by a combinational ideal MAC model with an
// optional fault term.
module tb_mac_stream_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   function automatic logic [15:0] mac_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [15:0] c);
      return c + ({{12{b[3]}}, b} * {12'd0, a});
   endfunction

   // ---------------- instance A: len 4, lat 1 ----------------
   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, err_flag_a, inj_a;
   logic [3:0]  in_x_a, in_w_a, mac_a_a, mac_b_a;
   logic [15:0] mac_c_a, mac_out_a, out_psum_a;
   logic [7:0]  err_cnt_a;
   assign mac_out_a = mac_model(mac_a_a, mac_b_a, mac_c_a) + {15'd0, inj_a};

   mac_stream_ctrl #(.bw(4), .psum_bw(16), .len(4), .mac_lat(1)) u_a (
      .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_x(in_x_a), .in_w(in_w_a), .mac_a(mac_a_a), .mac_b(mac_b_a), .mac_c(mac_c_a),
      .mac_out(mac_out_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_psum(out_psum_a), .err_cnt(err_cnt_a), .err_flag(err_flag_a));

   // ---------------- instance B: len 4, lat 3 ----------------
   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, err_flag_b;
   logic [3:0]  in_x_b, in_w_b, mac_a_b, mac_b_b;
   logic [15:0] mac_c_b, mac_out_b, out_psum_b;
   logic [7:0]  err_cnt_b;
   assign mac_out_b = mac_model(mac_a_b, mac_b_b, mac_c_b);

   mac_stream_ctrl #(.bw(4), .psum_bw(16), .len(4), .mac_lat(3)) u_b (
      .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_x(in_x_b), .in_w(in_w_b), .mac_a(mac_a_b), .mac_b(mac_b_b), .mac_c(mac_c_b),
      .mac_out(mac_out_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_psum(out_psum_b), .err_cnt(err_cnt_b), .err_flag(err_flag_b));

   // ---------------- instance C: len 255, lat 1 ----------------
   logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, err_flag_c, bad_c;
   logic [3:0]  in_x_c, in_w_c, mac_a_c, mac_b_c;
   logic [15:0] mac_c_c, mac_out_c, out_psum_c;
   logic [7:0]  err_cnt_c;
   assign mac_out_c = mac_model(mac_a_c, mac_b_c, mac_c_c) + {15'd0, bad_c};

   mac_stream_ctrl #(.bw(4), .psum_bw(16), .len(255), .mac_lat(1)) u_c (
      .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(in_ready_c),
      .in_x(in_x_c), .in_w(in_w_c), .mac_a(mac_a_c), .mac_b(mac_b_c), .mac_c(mac_c_c),
      .mac_out(mac_out_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
      .out_psum(out_psum_c), .err_cnt(err_cnt_c), .err_flag(err_flag_c));

   // ---------------- vector table (instance A groups) ----------------
   typedef struct {
      logic [3:0]  x[4];
      logic [3:0]  w[4];
      int          inj;     // pair index whose MAC result is off by +1, -1 = none
      logic [15:0] psum;
      logic [7:0]  err;
      logic        flag;
   } group_t;
   group_t tab[4];
   int hs_cyc;

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for DUT (t=%0t)", name, $time);
   endtask

   task automatic send_a(input logic [3:0] x, input logic [3:0] w, input logic inj,
                         input logic [15:0] acc_exp);
      int n = 0;
      @(negedge clk);
      while (!in_ready_a && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout("send_a");
      in_x_a = x; in_w_a = w; in_valid_a = 1'b1; inj_a = inj;
      @(posedge clk);
      #1;
      in_valid_a = 1'b0;
      hs_cyc = cyc;
      check("mac_a", {28'd0, mac_a_a}, {28'd0, x});
      check("mac_b", {28'd0, mac_b_a}, {28'd0, w});
      check("mac_c", {16'd0, mac_c_a}, {16'd0, acc_exp});
   endtask

   task automatic run_group_a(input int g, input logic chk_lat);
      logic [15:0] acc_m = 16'd0;
      int first = 0;
      int n = 0;
      for (int k = 0; k < 4; k++) begin
         send_a(tab[g].x[k], tab[g].w[k], tab[g].inj == k, acc_m);
         if (k == 0) first = hs_cyc;
         acc_m = mac_model(tab[g].x[k], tab[g].w[k], acc_m) + ((tab[g].inj == k) ? 16'd1 : 16'd0);
      end
      exp_q.push_back(tab[g].psum);
      @(negedge clk);
      while (!out_valid_a && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         timeout("group_out");
         void'(exp_q.pop_front());
      end else begin
         // Handshake cycle counts as cycle 0; out_valid must be high in cycle 8.
         if (chk_lat) check("out_latency", cyc - first + 1, 8);
         check("out_psum", {16'd0, out_psum_a}, {16'd0, exp_q.pop_front()});
         check("err_cnt", {24'd0, err_cnt_a}, {24'd0, tab[g].err});
         check("err_flag", {31'd0, err_flag_a}, {31'd0, tab[g].flag});
         check("in_ready_done", {31'd0, in_ready_a}, 32'd0);
      end
   endtask

   task automatic release_a();
      @(negedge clk);
      out_ready_a = 1'b1;
      @(posedge clk);
      #1;
      out_ready_a = 1'b0;
      check("out_valid_drop", {31'd0, out_valid_a}, 32'd0);
      check("in_ready_after", {31'd0, in_ready_a}, 32'd1);
   endtask

   task automatic wait_out_c(input logic [15:0] psum, input logic [7:0] err, input logic flag);
      int n = 0;
      @(negedge clk);
      while (!out_valid_c && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) timeout("c_out");
      else begin
         check("c_psum", {16'd0, out_psum_c}, {16'd0, psum});
         check("c_err_cnt", {24'd0, err_cnt_c}, {24'd0, err});
         check("c_err_flag", {31'd0, err_flag_c}, {31'd0, flag});
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      // (3,2)+(15,-8)+(0,7)+(7,-1) = 6-120+0-7 = -121
      tab[0] = '{'{4'd3, 4'd15, 4'd0, 4'd7}, '{4'h2, 4'h8, 4'h7, 4'hF}, -1, 16'hFF87, 8'd0, 1'b0};
      // same pairs, MAC +1 on the 2nd pair -> -120, one mismatch
      tab[1] = '{'{4'd3, 4'd15, 4'd0, 4'd7}, '{4'h2, 4'h8, 4'h7, 4'hF},  1, 16'hFF88, 8'd1, 1'b1};
      // 105+105+1+6 = 217; error state is sticky from the previous group
      tab[2] = '{'{4'd15, 4'd15, 4'd1, 4'd2}, '{4'h7, 4'h7, 4'h1, 4'h3}, -1, 16'h00D9, 8'd1, 1'b1};
      // -64-16+0-8 = -88
      tab[3] = '{'{4'd8, 4'd4, 4'd0, 4'd1}, '{4'h8, 4'hC, 4'h8, 4'h8},   -1, 16'hFFA8, 8'd1, 1'b1};

      reset = 1'b1;
      in_valid_a = 0; in_x_a = 0; in_w_a = 0; out_ready_a = 0; inj_a = 0;
      in_valid_b = 0; in_x_b = 0; in_w_b = 0; out_ready_b = 0;
      in_valid_c = 0; in_x_c = 0; in_w_c = 0; out_ready_c = 0; bad_c = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
      check("rst_out_psum", {16'd0, out_psum_a}, 32'd0);
      check("rst_mac_c", {16'd0, mac_c_a}, 32'd0);
      check("rst_err_cnt", {24'd0, err_cnt_a}, 32'd0);
      check("rst_err_flag", {31'd0, err_flag_a}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", {31'd0, in_ready_a}, 32'd1);

      // Group 0 with latency check, then 5 cycles of backpressure.
      run_group_a(0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", {31'd0, out_valid_a}, 32'd1);
         check("bp_out_psum", {16'd0, out_psum_a}, 32'h0000FF87);
         check("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
      end
      release_a();
      for (int g = 1; g < 4; g++) begin
         run_group_a(g, 1'b0);
         release_a();
      end

      // Latency sweep on B: in_valid held high, accepted every 4 cycles.
      begin
         logic [3:0] bx[4] = '{4'd5, 4'd9, 4'd12, 4'd2};
         logic [3:0] bw_[4] = '{4'h3, 4'hE, 4'h5, 4'h9};
         int k = 0;
         int n = 0;
         int last = 0;
         out_ready_b = 1'b1;
         in_x_b = bx[0]; in_w_b = bw_[0]; in_valid_b = 1'b1;
         while (k < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (in_ready_b) begin
               if (k > 0) check("b_ready_period", cyc - last, 4);
               last = cyc;
               k++;
               @(posedge clk);
               #1;
               if (k < 4) begin
                  in_x_b = bx[k]; in_w_b = bw_[k];
               end else begin
                  in_valid_b = 1'b0;
               end
            end
         end
         if (k < 4) timeout("b_accept");
         n = 0;
         @(negedge clk);
         while (!out_valid_b && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) timeout("b_out");
         else begin
            // 15-18+60-14 = 43
            check("b_psum", {16'd0, out_psum_b}, 32'h0000002B);
            check("b_err_cnt", {24'd0, err_cnt_b}, 32'd0);
         end
      end

      // Wrap and saturation on C: 255 x (15,-8).
      in_x_c = 4'd15; in_w_c = 4'h8; in_valid_c = 1'b1; out_ready_c = 1'b1;
      wait_out_c(16'h8878, 8'd0, 1'b0);    // -30600
      bad_c = 1'b1;
      wait_out_c(16'h8977, 8'd255, 1'b1);  // 255 x (-119) = -30345
      wait_out_c(16'h8977, 8'd255, 1'b1);  // count stays saturated
      in_valid_c = 1'b0;

      // Mid-operation reset on A during WAIT of the 3rd pair.
      send_a(tab[3].x[0], tab[3].w[0], 1'b0, 16'h0000);
      send_a(tab[3].x[1], tab[3].w[1], 1'b0, 16'hFFC0);
      send_a(tab[3].x[2], tab[3].w[2], 1'b0, 16'hFFB0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_in_ready", {31'd0, in_ready_a}, 32'd0);
      check("mid_rst_out_valid", {31'd0, out_valid_a}, 32'd0);
      check("mid_rst_mac_a", {28'd0, mac_a_a}, 32'd0);
      check("mid_rst_mac_c", {16'd0, mac_c_a}, 32'd0);
      check("mid_rst_err_cnt", {24'd0, err_cnt_a}, 32'd0);
      check("mid_rst_err_flag", {31'd0, err_flag_a}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_ready_back", {31'd0, in_ready_a}, 32'd1);
      check("mid_rst_no_out", {31'd0, out_valid_a}, 32'd0);
      run_group_a(0, 1'b0);
      release_a();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
